// File: rtl/frame_rx_decoder_if.sv
// Received-byte stream feeding the reply-frame decoder.
// master drives bytes (uart_rx side), slave consumes them (decoder).
interface frame_rx_decoder_if;
  logic       I_rx_data_valid;
  logic [7:0] I_rx_data;

  modport master (
    output I_rx_data_valid,
    output I_rx_data
  );

  modport slave (
    input I_rx_data_valid,
    input I_rx_data
  );
endinterface

// File: rtl/frame_rx_decoder.sv
// UART reply-frame parser: F0 | ADDR | FUNC | [LEN] | DATA | FF.
// Optional FUNC=3 sequence check under `FRAME_RX_SEQ_CHECK_EN.
module frame_rx_decoder #(
  parameter int BULK_WORDS     = 1000,
  parameter int SHORT_WORDS    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                I_clk,
  input  logic                I_rst,
  frame_rx_decoder_if.slave   rx,
  input  logic [7:0]          I_device_addr,
  output logic                O_busy,
  output logic [7:0]          O_frame_func,
  output logic [15:0]         O_frame_seq,
  output logic                O_word_valid,
  output logic [15:0]         O_word,
  output logic                O_frame_done,
  output logic                O_frame_err,
  output logic [2:0]          O_err_code
);

  typedef enum logic [2:0] {
    SIDLE, SADDR, SFUNC, SLENT, SDATA, STAIL
  } state_t;

  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] BULK_LAST  = 16'(2 * BULK_WORDS - 1);
  localparam logic [15:0] SHORT_LAST = 16'(2 * SHORT_WORDS - 1);
  localparam logic [GW-1:0] GAP_LIM  = GW'(TIMEOUT_CYCLES - 1);

  state_t        state_q;
  logic [7:0]    func_q;
  logic [15:0]   seq_q;
  logic [7:0]    lenhi_q;
  logic          lcnt_q;
  logic [15:0]   cnt_q;
  logic [7:0]    hold_q;
  logic          bulk_q;
  logic [15:0]   word_q;
  logic          word_vld_q;
  logic          done_q;
  logic          err_q;
  logic [2:0]    code_q;
  logic [GW-1:0] gap_q;

`ifdef FRAME_RX_SEQ_CHECK_EN
  logic          need_new_q;
  logic          seq_bad_q;
  logic [15:0]   last_seq_q;
  logic [15:0]   len_d;
  logic          seq_bad_d;
`endif

  logic          vld;
  logic [7:0]    rxb;
  logic          timeout_d;
  logic          abort_d;
  logic [2:0]    abort_code_d;
  logic [15:0]   last_idx_d;

  assign vld        = rx.I_rx_data_valid;
  assign rxb        = rx.I_rx_data;
  assign timeout_d  = (state_q != SIDLE) && !vld && (gap_q == GAP_LIM);
  assign last_idx_d = bulk_q ? BULK_LAST : SHORT_LAST;

`ifdef FRAME_RX_SEQ_CHECK_EN
  // LEN=1 always restarts a burst; otherwise it must follow the last good LEN
  assign len_d     = {lenhi_q, rxb};
  assign seq_bad_d = (len_d != 16'd1) &&
                     (need_new_q || len_d != last_seq_q + 16'd1);
`endif

  // Decide whether this cycle aborts the frame and with which cause
  always_comb begin
    abort_d      = 1'b0;
    abort_code_d = 3'd0;
    if (timeout_d) begin
      abort_d      = 1'b1;
      abort_code_d = 3'd4;
    end else if (vld) begin
      unique case (state_q)
        SADDR: if (rxb != I_device_addr) begin
          abort_d      = 1'b1;
          abort_code_d = 3'd1;
        end
        SFUNC: if (rxb == 8'd0 || rxb > 8'd4) begin
          abort_d      = 1'b1;
          abort_code_d = 3'd2;
        end
        STAIL: if (rxb != 8'hFF) begin
          abort_d      = 1'b1;
          abort_code_d = 3'd3;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM with registered outputs and inter-byte gap timer
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= SIDLE;
      func_q     <= '0;
      seq_q      <= '0;
      lenhi_q    <= '0;
      lcnt_q     <= 1'b0;
      cnt_q      <= '0;
      hold_q     <= '0;
      bulk_q     <= 1'b0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      gap_q      <= '0;
`ifdef FRAME_RX_SEQ_CHECK_EN
      need_new_q <= 1'b1;
      seq_bad_q  <= 1'b0;
      last_seq_q <= '0;
`endif
    end else begin
      word_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      if (vld || state_q == SIDLE) gap_q <= '0;
      else gap_q <= gap_q + 1'b1;

      // FUNC is latched even when the value is rejected
      if (vld && state_q == SFUNC) func_q <= rxb;

      if (abort_d) begin
        err_q   <= 1'b1;
        code_q  <= abort_code_d;
        state_q <= SIDLE;
        hold_q  <= '0;
        cnt_q   <= '0;
        lcnt_q  <= 1'b0;
`ifdef FRAME_RX_SEQ_CHECK_EN
        need_new_q <= 1'b1;
        seq_bad_q  <= 1'b0;
`endif
      end else if (vld) begin
        unique case (state_q)
          SIDLE: if (rxb == 8'hF0) begin
            state_q <= SADDR;
            code_q  <= '0;
          end
          SADDR: state_q <= SFUNC;
          SFUNC: begin
            bulk_q <= (rxb == 8'd3);
            lcnt_q <= 1'b0;
            cnt_q  <= '0;
            state_q <= (rxb == 8'd3) ? SLENT : SDATA;
          end
          SLENT: begin
            if (!lcnt_q) begin
              lenhi_q <= rxb;
              lcnt_q  <= 1'b1;
            end else begin
              seq_q   <= {lenhi_q, rxb};
              lcnt_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= SDATA;
`ifdef FRAME_RX_SEQ_CHECK_EN
              seq_bad_q <= seq_bad_d;
`endif
            end
          end
          SDATA: begin
            if (!cnt_q[0]) begin
              hold_q <= rxb;
            end else begin
              word_q     <= {hold_q, rxb};
              word_vld_q <= 1'b1;
            end
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == last_idx_d) state_q <= STAIL;
          end
          STAIL: begin
            state_q <= SIDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
`ifdef FRAME_RX_SEQ_CHECK_EN
            if (bulk_q && seq_bad_q) begin
              err_q  <= 1'b1;
              code_q <= 3'd5;
            end else begin
              done_q <= 1'b1;
              if (bulk_q) begin
                last_seq_q <= seq_q;
                need_new_q <= 1'b0;
              end
            end
            seq_bad_q <= 1'b0;
`else
            done_q <= 1'b1;
`endif
          end
          default: state_q <= SIDLE;
        endcase
      end
    end
  end

  assign O_busy       = (state_q != SIDLE);
  assign O_frame_func = func_q;
  assign O_frame_seq  = seq_q;
  assign O_word_valid = word_vld_q;
  assign O_word       = word_q;
  assign O_frame_done = done_q;
  assign O_frame_err  = err_q;
  assign O_err_code   = code_q;

endmodule

// File: doc/frame_rx_decoder.md
Name: frame_rx_decoder

Overview:
Receive-side parser for the board's UART reply frame: F0 | ADDR | FUNC | [LEN_H LEN_L, FUNC=3 only] | DATA | FF.
Consumes bytes from the uart_rx byte interface and validates each frame field by field. Reassembles DATA into 16-bit words, MSB byte first.
Used in loopback or host-emulation paths to check the output of the command-execution block, and by downstream logic that needs decoded sample words.

Parameters:
BULK_WORDS, 1000, words carried by a FUNC=3 frame (2*BULK_WORDS data bytes)
SHORT_WORDS, 1, words carried by FUNC=1/2/4 frames
TIMEOUT_CYCLES, 100000, max idle clocks between bytes inside a frame before abort

Ports:
I_clk  in  1  system clock
I_rst  in  1  asynchronous reset, active-high
I_rx_data_valid  in  1  one-cycle strobe, I_rx_data holds a received byte
I_rx_data  in  8  received byte
I_device_addr  in  8  expected ADDR field
O_busy  out  1  high whenever state != SIDLE
O_frame_func  out  8  FUNC of the current or last frame
O_frame_seq  out  16  LEN field of the current or last FUNC=3 frame
O_word_valid  out  1  one-cycle pulse, O_word is valid
O_word  out  16  reassembled data word
O_frame_done  out  1  one-cycle pulse, good tail accepted
O_frame_err  out  1  one-cycle pulse, frame aborted
O_err_code  out  3  cause of last abort; held until next F0 accepted

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0, state to SIDLE, counters to 0.
- States and transitions:
  - SIDLE: a byte F0 moves to SADDR; any other byte is discarded silently.
  - SADDR: byte == I_device_addr moves to SFUNC; otherwise abort with code 1.
  - SFUNC: byte is latched to O_frame_func. Value 3 moves to SLENT. Values 1, 2, 4 move to SDATA. Any other value aborts with code 2.
  - SLENT: two bytes, MSB first. O_frame_seq updates on the second byte, then moves to SDATA.
  - SDATA: expects 2*BULK_WORDS bytes if FUNC=3, else 2*SHORT_WORDS bytes. Even-indexed byte goes to a high holding register. Odd-indexed byte makes O_word={high,byte} and pulses O_word_valid on the next clock. After the last byte, moves to STAIL.
  - STAIL: byte FF pulses O_frame_done and returns to SIDLE. Any other byte aborts with code 3.
- Data byte counter is 16 bits and is cleared on entry to SDATA.
- Latency: all registered outputs (O_word/O_word_valid, O_frame_done, O_frame_err, O_err_code, O_frame_func, O_frame_seq) update on the clock after the accepting I_rx_data_valid cycle.
- Abort actions:
  - O_frame_err pulses for 1 cycle and O_err_code is loaded.
  - State returns to SIDLE; the holding register and counters clear.
  - The aborting byte is not re-examined as a possible F0.
- Timeout:
  - Gap counter clears on every I_rx_data_valid and counts while state != SIDLE.
  - When it reaches TIMEOUT_CYCLES with no byte that cycle, abort with code 4.
  - A byte arriving in the same cycle the limit would be reached wins: it is processed and the counter clears.
- Accepting F0 in SIDLE clears O_err_code to 0.
- O_frame_func and O_frame_seq hold until overwritten.
- Back-to-back frames: F0 on the clock immediately after the FF tail is accepted; no gap is required.
- Reset asserted mid-frame drops the partial frame. No done or err pulse is generated.
- I_rx_data_valid is never stalled; the decoder accepts one byte per clock.

Optional Feature:
FRAME_RX_SEQ_CHECK_EN
- Defined:
  - The decoder tracks the expected sequence for FUNC=3 frames.
  - A frame with LEN=1 always starts a new burst.
  - Otherwise LEN must equal the last good FUNC=3 LEN + 1.
  - On mismatch, the frame is still parsed to the tail and its words are output. At the tail, O_frame_err pulses with code 5 instead of O_frame_done.
  - Any abort or timeout forces the next FUNC=3 frame to need LEN=1.
- Undefined: LEN is captured to O_frame_seq only; code 5 never occurs.

Test Plan:
- F0 2A 01 12 34 FF with I_device_addr=2A -> one word 0x1234, O_frame_func=1, O_frame_done pulse, no err.
- F0 2A 03 00 01, then 2000 bytes i&0xFF, then FF (BULK_WORDS=1000) -> 1000 O_word_valid pulses, O_word values 0x0001,0x0203,…, O_frame_seq=1, one done pulse.
- Garbage 00 55 F0 2B with I_device_addr=2A -> leading bytes ignored, err pulse, O_err_code=1. A following valid frame decodes and O_err_code clears to 0.
- F0 2A 07 -> err code 2. Separately, F0 2A 02 00 05 EE -> err code 3; the word 0x0005 is still output before the err.
- F0 2A 04 00, then silence for TIMEOUT_CYCLES clocks -> err code 4, O_busy low. A byte at exactly cycle TIMEOUT_CYCLES-1 instead continues the frame.
- FRAME_RX_SEQ_CHECK_EN defined: FUNC=3 frames with LEN 1,2,4 -> done, done, err code 5. Then LEN 5 -> err code 5; then LEN 1 -> done.
